// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions for the move scheduler and the search logic built on it.
// Holds cell codes, board geometry, the win score, the centre-first column order and the scheduler states.
// Board layout: cell(r,c) sits at bits [14r+2c+1:14r+2c]; row 0 is the top row, row 5 the bottom row.
package connect4_pkg;

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    AI          = 2'd1,
    HUMAN       = 2'd2,
    OUTOFBOUNDS = 2'd3
  } cell_t;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int CELL_W    = 2;
  localparam int BOARD_W   = ROWS * COLS * CELL_W;  // 84
  localparam int WIN_SCORE = 100000;

  // Centre-first visiting order, order index 0 in the low bits: 3,2,4,1,5,0,6.
  localparam logic [20:0] COL_ORDER = {3'd6, 3'd0, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND_ROW,
    S_LAUNCH,
    S_WAIT_ARM,
    S_WAIT_DONE,
    S_COMPARE,
    S_NEXT,
    S_FINISH
  } sched_state_t;

  // Column visited at a given order index; 7 for an index past the end.
  function automatic logic [2:0] order_col(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = COL_ORDER[2:0];
      3'd1:    c = COL_ORDER[5:3];
      3'd2:    c = COL_ORDER[8:6];
      3'd3:    c = COL_ORDER[11:9];
      3'd4:    c = COL_ORDER[14:12];
      3'd5:    c = COL_ORDER[17:15];
      3'd6:    c = COL_ORDER[20:18];
      default: c = 3'd7;
    endcase
    return c;
  endfunction

  // Cell code at (r,c); OUTOFBOUNDS for coordinates off the board.
  function automatic logic [1:0] get_cell(input logic [BOARD_W-1:0] b,
                                          input logic [2:0]         r,
                                          input logic [2:0]         c);
    logic [1:0] v;
    v = OUTOFBOUNDS;
    for (int ri = 0; ri < ROWS; ri++) begin
      for (int ci = 0; ci < COLS; ci++) begin
        if (r == 3'(ri) && c == 3'(ci)) begin
          v = b[CELL_W*(COLS*ri+ci) +: CELL_W];
        end
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/drop_piece.sv
// Builds a child board by writing PIECE into cell (row, column) of the parent board.
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: board (parent position), column/row (target cell), child (parent with that cell overwritten).
module drop_piece
  import connect4_pkg::*;
#(
  parameter logic [1:0] PIECE = 2'd1
) (
  input  logic [BOARD_W-1:0] board,
  input  logic [2:0]         column,
  input  logic [2:0]         row,
  output logic [BOARD_W-1:0] child
);

  // Out-of-range coordinates leave the board untouched.
  always_comb begin
    child = board;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row == 3'(r) && column == 3'(c)) begin
          child[CELL_W*(COLS*r+c) +: CELL_W] = PIECE;
        end
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Picks the AI's next Connect-4 move by running the board evaluator once per legal column, centre first.
// Latency: per legal column (row scan + launch + arm + evaluator + compare + next), plus one finish cycle.
// Backpressure: start is only accepted in IDLE; the evaluator is waited on with a per-column timeout.
//
// Ports:
//   clk, reset (async active-low)     : clock and reset
//   start, board_in, abort            : search request, position to search, cancel
//   busy, done                        : search in progress, one-cycle result pulse
//   best_col, best_score, timeout_flag: result column (7 = no legal move), its score, any-column-timed-out
//   eval_enable, eval_board           : evaluator enable and child board
//   eval_stable, eval_score           : evaluator completion and result
//
// Build option: define EARLY_WIN_EN to end the search as soon as a column scores WIN_SCORE or more.
module move_scheduler
  import connect4_pkg::*;
#(
  parameter int         SCORE_W      = 32,
  parameter int         EVAL_TIMEOUT = 4096,
  parameter logic [1:0] PIECE        = 2'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BOARD_W-1:0]        board_in,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                best_col,
  output logic signed [SCORE_W-1:0] best_score,
  output logic                      timeout_flag,
  output logic                      eval_enable,
  output logic [BOARD_W-1:0]        eval_board,
  input  logic                      eval_stable,
  input  logic signed [SCORE_W-1:0] eval_score
);

  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam int                        TCNT_W    = (EVAL_TIMEOUT > 2) ? $clog2(EVAL_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0]         TCNT_LAST = TCNT_W'(EVAL_TIMEOUT - 1);

  sched_state_t              state;
  logic [BOARD_W-1:0]        board_q;
  logic [2:0]                order_idx;
  logic [2:0]                row;
  logic [TCNT_W-1:0]         tcnt;
  logic signed [SCORE_W-1:0] score_q;

  // Running best for the search in progress; only copied to the outputs on
  // completion so an aborted search leaves the previous result visible.
  logic                      have_cand;
  logic [2:0]                cand_col;
  logic signed [SCORE_W-1:0] cand_score;

  logic [2:0]                cur_col;
  logic [1:0]                cur_cell;
  logic [BOARD_W-1:0]        child;

  assign cur_col  = order_col(order_idx);
  assign cur_cell = get_cell(board_q, row, cur_col);

  drop_piece #(
    .PIECE (PIECE)
  ) u_drop_piece (
    .board  (board_q),
    .column (cur_col),
    .row    (row),
    .child  (child)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      board_q      <= '0;
      order_idx    <= '0;
      row          <= 3'd5;
      tcnt         <= '0;
      score_q      <= '0;
      have_cand    <= 1'b0;
      cand_col     <= 3'd7;
      cand_score   <= SCORE_MIN;
      busy         <= 1'b0;
      done         <= 1'b0;
      best_col     <= 3'd7;
      best_score   <= SCORE_MIN;
      timeout_flag <= 1'b0;
      eval_enable  <= 1'b0;
      eval_board   <= '0;
    end else if (abort && state != S_IDLE) begin
      state       <= S_IDLE;
      eval_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            board_q      <= board_in;
            timeout_flag <= 1'b0;
            busy         <= 1'b1;
            order_idx    <= '0;
            row          <= 3'd5;
            have_cand    <= 1'b0;
            state        <= S_FIND_ROW;
          end
        end

        // Bottom-up scan: the first empty cell is where the piece lands.
        S_FIND_ROW: begin
          if (cur_cell == EMPTY) begin
            state <= S_LAUNCH;
          end else if (row == 3'd0) begin
            state <= S_NEXT;
          end else begin
            row <= row - 3'd1;
          end
        end

        S_LAUNCH: begin
          eval_board  <= child;
          eval_enable <= 1'b1;
          tcnt        <= '0;
          state       <= S_WAIT_ARM;
        end

        // A stable left over from the previous column must drop before the
        // next stable can be trusted as this column's result.
        S_WAIT_ARM: begin
          if (tcnt == TCNT_LAST) begin
            timeout_flag <= 1'b1;
            eval_enable  <= 1'b0;
            if (!have_cand) begin
              have_cand  <= 1'b1;
              cand_col   <= cur_col;
              cand_score <= SCORE_MIN;
            end
            state <= S_NEXT;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
            if (!eval_stable) begin
              state <= S_WAIT_DONE;
            end
          end
        end

        // A result arriving on the last allowed cycle still counts.
        S_WAIT_DONE: begin
          if (eval_stable) begin
            score_q <= eval_score;
            state   <= S_COMPARE;
          end else if (tcnt == TCNT_LAST) begin
            timeout_flag <= 1'b1;
            eval_enable  <= 1'b0;
            if (!have_cand) begin
              have_cand  <= 1'b1;
              cand_col   <= cur_col;
              cand_score <= SCORE_MIN;
            end
            state <= S_NEXT;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        // Strict compare: on a tie the earlier, more central column stays.
        S_COMPARE: begin
          eval_enable <= 1'b0;
          if (!have_cand || score_q > cand_score) begin
            have_cand  <= 1'b1;
            cand_col   <= cur_col;
            cand_score <= score_q;
          end
          state <= S_NEXT;
`ifdef EARLY_WIN_EN
          // A four-in-a-row child cannot be beaten; finish with it now.
          if (score_q >= WIN_S) begin
            have_cand  <= 1'b1;
            cand_col   <= cur_col;
            cand_score <= score_q;
            best_col   <= cur_col;
            best_score <= score_q;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_FINISH;
          end
`endif
        end

        // Enable is low here, letting the evaluator return to idle between runs.
        S_NEXT: begin
          if (order_idx == 3'd6) begin
            best_col   <= have_cand ? cand_col : 3'd7;
            best_score <= have_cand ? cand_score : SCORE_MIN;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_FINISH;
          end else begin
            order_idx <= order_idx + 3'd1;
            row       <= 3'd5;
            state     <= S_FIND_ROW;
          end
        end

        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          eval_enable <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

`ifndef EARLY_WIN_EN
  // Early-win threshold is only consulted when the early-exit build is selected.
  logic unused_win;
  assign unused_win = ^WIN_S;
`endif

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed cases plus randomized boards and scores,
// checked against a column-by-column reference model of the search.
module tb_move_scheduler;
  import connect4_pkg::*;

  localparam int SW   = 32;
  localparam int TO   = 16;
  localparam int SMIN = 32'sh8000_0000;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [83:0]          board_in;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [2:0]           best_col;
  logic signed [SW-1:0] best_score;
  logic                 timeout_flag;
  logic                 eval_enable;
  logic [83:0]          eval_board;
  logic                 eval_stable;
  logic signed [SW-1:0] eval_score;

  move_scheduler #(
    .SCORE_W      (SW),
    .EVAL_TIMEOUT (TO),
    .PIECE        (2'd1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .board_in     (board_in),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .best_col     (best_col),
    .best_score   (best_score),
    .timeout_flag (timeout_flag),
    .eval_enable  (eval_enable),
    .eval_board   (eval_board),
    .eval_stable  (eval_stable),
    .eval_score   (eval_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scenario description
  int          h[7];      // column heights (pieces stacked from the bottom)
  int          sc[7];     // evaluator score per column
  int          lat;       // evaluator latency in cycles
  int          hang_col;  // column whose evaluation never completes; 7 = none
  logic [83:0] tb_board;
  int          order_tbl[7] = '{3, 2, 4, 1, 5, 0, 6};

  // Reference results
  int exp_q[$];
  int exp_col;
  int exp_score;
  bit exp_to;
  int exp_lat;

  // Evaluator model observations
  int          seen_cols[$];
  logic [83:0] seen_boards[$];
  int          ev_cnt;
  int          ev_col;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_col(input logic [83:0] b);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (b[14*r+2*c +: 2] != tb_board[14*r+2*c +: 2]) return c;
    return 7;
  endfunction

  function automatic logic [83:0] child_of(input int c);
    logic [83:0] b;
    b = tb_board;
    b[14*(5-h[c])+2*c +: 2] = 2'd1;
    return b;
  endfunction

  task automatic make_board();
    tb_board = '0;
    for (int c = 0; c < 7; c++)
      for (int k = 0; k < h[c]; k++)
        tb_board[14*(5-k)+2*c +: 2] = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2;
    board_in = tb_board;
  endtask

  // Evaluator: drops stable when a run starts, raises it lat cycles later,
  // and leaves it high (stale) after enable falls.
  always @(negedge clk) begin
    if (!eval_enable) begin
      ev_cnt = 0;
    end else begin
      if (ev_cnt == 0) begin
        eval_stable = 1'b0;
        ev_col      = find_col(eval_board);
        seen_cols.push_back(ev_col);
        seen_boards.push_back(eval_board);
      end else if (ev_cnt == lat && ev_col != hang_col) begin
        eval_stable = 1'b1;
        eval_score  = (ev_col < 7) ? sc[ev_col] : 0;
      end
      ev_cnt++;
    end
  end

  // Search as the rules state it: centre-first over non-full columns, strict
  // improvement, timed-out column scores minimum and is kept only if nothing is held.
  task automatic ref_model();
    bit have;
    int best, bc, c;
    have = 0; best = SMIN; bc = 7;
    exp_q.delete();
    exp_to  = 0;
    exp_lat = 1;
    for (int i = 0; i < 7; i++) begin
      c = order_tbl[i];
      if (h[c] == 6) begin
        exp_lat += 7;
        continue;
      end
      exp_q.push_back(c);
      if (c == hang_col) begin
        exp_to = 1;
        exp_lat += (h[c] + 1) + 1 + TO + 1;
        if (!have) begin have = 1; bc = c; best = SMIN; end
      end else begin
        exp_lat += (h[c] + 1) + 1 + 1 + lat + 1 + 1;
        if (!have || sc[c] > best) begin have = 1; bc = c; best = sc[c]; end
`ifdef EARLY_WIN_EN
        if (sc[c] >= WIN_SCORE) begin
          bc = c; best = sc[c];
          exp_lat -= 1;
          break;
        end
`endif
      end
    end
    exp_col   = have ? bc : 7;
    exp_score = have ? best : SMIN;
  endtask

  task automatic run_search(input string name);
    int  cyc;
    bit  got_done;
    int  n;
    ref_model();
    seen_cols.delete();
    seen_boards.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    got_done = 0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (busy || done) cyc++;
      if (done) got_done = 1;
      else @(negedge clk);
    end
    check({name, "/done_seen"}, got_done, 1);
    if (got_done) begin
      check({name, "/best_col"}, best_col, exp_col);
      check({name, "/best_score"}, best_score, exp_score);
      check({name, "/timeout_flag"}, timeout_flag, exp_to);
      check({name, "/latency"}, cyc, exp_lat);
      check({name, "/busy_at_done"}, busy, 0);
      @(negedge clk);
      check({name, "/done_width"}, done, 0);
    end
    check({name, "/runs"}, seen_cols.size(), exp_q.size());
    n = (seen_cols.size() < exp_q.size()) ? seen_cols.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "/run_col"}, seen_cols[i], exp_q[i]);
      check({name, "/child_board"}, seen_boards[i], child_of(exp_q[i]));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev_col, prev_score, dcnt;
    reset = 1'b0; start = 1'b0; abort = 1'b0; board_in = '0;
    eval_stable = 1'b0; eval_score = '0; ev_cnt = 0; ev_col = 7;
    lat = 1; hang_col = 7;
    for (int c = 0; c < 7; c++) begin h[c] = 0; sc[c] = 0; end
    tb_board = '0;
    #23;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/best_col", best_col, 7);
    check("rst/best_score", best_score, SMIN);
    check("rst/timeout_flag", timeout_flag, 0);
    check("rst/eval_enable", eval_enable, 0);
    @(negedge clk);
    reset = 1'b1;

    // Empty board, equal scores: centre column wins.
    for (int c = 0; c < 7; c++) begin h[c] = 0; sc[c] = 5; end
    lat = 3; hang_col = 7; make_board();
    run_search("empty");

    // Centre columns full, tie between 1 and 2 goes to the more central 2.
    for (int c = 0; c < 7; c++) h[c] = $urandom_range(0, 5);
    h[3] = 6; h[4] = 6;
    sc[0] = -20; sc[1] = 40; sc[2] = 40; sc[3] = 99; sc[4] = 99; sc[5] = 10; sc[6] = 0;
    lat = 2; make_board();
    run_search("full34");

    // Board full: no evaluation, no legal move.
    for (int c = 0; c < 7; c++) h[c] = 6;
    make_board();
    run_search("allfull");

    // Column 2 never finishes.
    for (int c = 0; c < 7; c++) begin h[c] = 0; sc[c] = c * 3 - 7; end
    lat = 4; hang_col = 2; make_board();
    run_search("hang2");

    // Winning child in column 2.
    for (int c = 0; c < 7; c++) begin h[c] = 0; sc[c] = 10; end
    sc[2] = WIN_SCORE; lat = 2; hang_col = 7; make_board();
    run_search("win2");

    // Abort while waiting on the evaluator.
    prev_col = exp_col; prev_score = exp_score;
    for (int c = 0; c < 7; c++) begin h[c] = 0; sc[c] = 5; end
    lat = 10; hang_col = 7; make_board();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && !eval_enable; k++) @(negedge clk);
    check("abort/en_rise", eval_enable, 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/eval_enable", eval_enable, 0);
    check("abort/busy", busy, 0);
    check("abort/done", done, 0);
    check("abort/best_col", best_col, prev_col);
    check("abort/best_score", best_score, prev_score);
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy || eval_enable) dcnt++;
    end
    check("abort/quiet", dcnt, 0);

    // Reset in the middle of a search.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst/busy", busy, 0);
    check("midrst/eval_enable", eval_enable, 0);
    check("midrst/best_col", best_col, 7);
    check("midrst/best_score", best_score, SMIN);
    check("midrst/timeout_flag", timeout_flag, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin h[c] = c % 3; sc[c] = 20 - c; end
    lat = 1; make_board();
    run_search("after_rst");

    // Randomized positions, scores, latencies and occasional hung columns.
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < 7; c++) begin
        h[c]  = $urandom_range(0, 8);
        if (h[c] > 6) h[c] = 6;
        sc[c] = int'($urandom_range(0, 100)) - 50;
      end
      lat      = $urandom_range(1, 6);
      hang_col = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 7;
      make_board();
      run_search("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
